interp_upsampler: RTL and testbench

Parametrised upsampling interpolator between the sample FIFO and the DAC/output path. It pulls one input sample per output period from the upstream FIFO and emits 2^R output samples per input sample, one per clock. It supports four modes: bypass, zero-order hold, zero-stuffing and linear interpolation. It supersedes the pass-through (no-interpolation) stage, which is exactly this block with R=0.

---
 rtl/interp_upsampler.sv | 155 +++++++++++++++
 tb/tb_interp_upsampler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/interp_upsampler.sv
// rtl/interp_upsampler.sv - 2^R upsampling interpolator (bypass / ZOH / zero-stuff / linear)
//
// Pulls one sample per output period from a standard (non-FWFT) FIFO and
// emits 2^R output samples per input sample, one per clock.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   ena         in   FIFO ready flag; a read may be issued while high
//   rd_en       out  FIFO read strobe (combinational from phase counter/ena)
//   data_in     in   FIFO read data, valid the cycle after rd_en
//   mode        in   00 bypass, 01 zero-order hold, 10 zero-stuff, 11 linear
//   ratio_log2  in   interpolation exponent R, clamped to MAX_LOG2
//   dout        out  registered output sample
//   dout_valid  out  dout carries a valid sample

module interp_upsampler #(
    parameter int DATA_W   = 16,
    parameter int MAX_LOG2 = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               ena,
    output logic                               rd_en,
    input  logic signed [DATA_W-1:0]           data_in,
    input  logic        [1:0]                  mode,
    input  logic        [$clog2(MAX_LOG2+1)-1:0] ratio_log2,
    output logic signed [DATA_W-1:0]           dout,
    output logic                               dout_valid
);

    localparam int RW = $clog2(MAX_LOG2 + 1);
    localparam int PW = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;
    localparam int XW = DATA_W + 1 + MAX_LOG2;

    // Index of the last phase for exponent r: a mask of r ones.
    function automatic logic [PW-1:0] last_phase(input logic [RW-1:0] r);
        logic [PW-1:0] ones;
        ones = '1;
        return ~(ones << r);
    endfunction

    // Read side: phase counter and settings latched at the read.
    logic [PW-1:0] r_rcnt;
    logic [1:0]    r_mode_q;
    logic [RW-1:0] r_rq;
    logic [RW-1:0] w_r_in;

    // Capture / output side: settings for the period currently being emitted.
    logic                     r_cap;
    logic                     r_primed;
    logic signed [DATA_W-1:0] r_prev;
    logic signed [DATA_W-1:0] r_cur;
    logic [1:0]               r_mode_o;
    logic [RW-1:0]            r_ro;
    logic [PW-1:0]            r_p;
    logic                     r_act;

    logic signed [DATA_W:0]   w_diff;
    logic signed [XW-1:0]     w_diff_x;
    logic signed [XW-1:0]     w_p_x;
    logic signed [XW-1:0]     w_prod;
    logic signed [XW-1:0]     w_shift;
    logic [DATA_W-1:0]        w_lin;
    logic [DATA_W-1:0]        w_out;

    assign rd_en = ena && (r_rcnt == '0);

    // Bypass always runs at L=1 whatever ratio_log2 says.
    always_comb begin
        w_r_in = ratio_log2;
        if (mode == 2'b00) begin
            w_r_in = '0;
        end else if (ratio_log2 > RW'(MAX_LOG2)) begin
            w_r_in = RW'(MAX_LOG2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rcnt   <= '0;
            r_mode_q <= '0;
            r_rq     <= '0;
        end else if (rd_en) begin
            r_mode_q <= mode;
            r_rq     <= w_r_in;
            r_rcnt   <= (w_r_in == '0) ? '0 : PW'(1);
        end else if (r_rcnt != '0) begin
            r_rcnt <= (r_rcnt == last_phase(r_rq)) ? '0 : r_rcnt + PW'(1);
        end
    end

    // Settings move to the output side at capture, so the period still being
    // emitted is not disturbed by the read that overlaps its tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap    <= 1'b0;
            r_primed <= 1'b0;
            r_prev   <= '0;
            r_cur    <= '0;
            r_mode_o <= '0;
            r_ro     <= '0;
            r_p      <= '0;
            r_act    <= 1'b0;
        end else begin
            r_cap <= rd_en;
            if (r_cap) begin
                r_prev   <= r_primed ? r_cur : data_in;
                r_cur    <= data_in;
                r_primed <= 1'b1;
                r_mode_o <= r_mode_q;
                r_ro     <= r_rq;
                r_p      <= '0;
                r_act    <= 1'b1;
            end else if (r_act) begin
                if (r_p == last_phase(r_ro)) begin
                    r_act <= 1'b0;
                end else begin
                    r_p <= r_p + PW'(1);
                end
            end
        end
    end

    // prev + ((cur - prev) * p) >>> R; the true result always fits DATA_W,
    // so the add can be done modulo 2^DATA_W on the low bits.
    assign w_diff   = {r_cur[DATA_W-1], r_cur} - {r_prev[DATA_W-1], r_prev};
    assign w_diff_x = {{MAX_LOG2{w_diff[DATA_W]}}, w_diff};
    assign w_p_x    = {{(XW-PW){1'b0}}, r_p};
    assign w_prod   = w_diff_x * w_p_x;
    assign w_shift  = w_prod >>> r_ro;
    assign w_lin    = r_prev + w_shift[DATA_W-1:0];

    always_comb begin
        w_out = r_cur;
        case (r_mode_o)
            2'b10:   w_out = (r_p == '0) ? r_cur : '0;
            2'b11:   w_out = w_lin;
            default: w_out = r_cur;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= r_act;
            if (r_act) begin
                dout <= w_out;
            end
        end
    end

endmodule

// File: tb/tb_interp_upsampler.sv
// tb/tb_interp_upsampler.sv - self-checking bench for interp_upsampler

module tb_interp_upsampler;

    localparam int DATA_W   = 16;
    localparam int MAX_LOG2 = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     ena = 1'b0;
    logic                     rd_en;
    logic signed [DATA_W-1:0] data_in = '0;
    logic [1:0]               mode = 2'b00;
    logic [2:0]               ratio_log2 = '0;
    logic signed [DATA_W-1:0] dout;
    logic                     dout_valid;

    always #5 clk = ~clk;

    interp_upsampler #(.DATA_W(DATA_W), .MAX_LOG2(MAX_LOG2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rd_en(rd_en),
        .data_in(data_in), .mode(mode), .ratio_log2(ratio_log2),
        .dout(dout), .dout_valid(dout_valid)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a timeline of expected outputs indexed by cycle.
    int cyc, next_free, reads, last_exp;
    bit m_primed;
    int m_prev, m_cur;
    int exp_v[int];
    int data_sched[int];
    int in_q[$];
    int out_q[$];

    typedef struct {
        logic [1:0] md;
        int         r;
        int         n;
        int         din[3];
        int         nout;
        int         dq[12];
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q--;
        return q;
    endfunction

    function automatic int rnd_sample();
        logic signed [DATA_W-1:0] x;
        x = DATA_W'($urandom);
        return int'(x);
    endfunction

    task automatic model_reset();
        cyc = 0; next_free = 0; reads = 0; last_exp = 0;
        m_primed = 0; m_prev = 0; m_cur = 0;
        exp_v.delete(); data_sched.delete();
        in_q.delete(); out_q.delete();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        ena = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic step(input bit e, input logic [1:0] md, input int rl);
        int r, len, v, val;
        bit exp_rd;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_v.exists(cyc)) begin
            chk("dout_valid", int'(dout_valid), 1);
            chk("dout", int'(dout), exp_v[cyc]);
            last_exp = exp_v[cyc];
        end else begin
            chk("dout_valid_idle", int'(dout_valid), 0);
            chk("dout_hold", int'(dout), last_exp);
        end
        if (dout_valid) out_q.push_back(int'(dout));
        ena = e;
        mode = md;
        ratio_log2 = 3'(rl);
        data_in = data_sched.exists(cyc) ? DATA_W'(data_sched[cyc]) : DATA_W'($urandom);
        #1;
        exp_rd = e && (cyc >= next_free);
        chk("rd_en", int'(rd_en), int'(exp_rd));
        if (exp_rd) begin
            v = (in_q.size() > 0) ? in_q.pop_front() : rnd_sample();
            r = (md == 2'b00) ? 0 : ((rl > MAX_LOG2) ? MAX_LOG2 : rl);
            len = 1 << r;
            next_free = cyc + len;
            data_sched[cyc + 1] = v;
            m_prev = m_primed ? m_cur : v;
            m_cur = v;
            m_primed = 1;
            for (int p = 0; p < len; p++) begin
                case (md)
                    2'b10:   val = (p == 0) ? m_cur : 0;
                    2'b11:   val = m_prev + fdiv((m_cur - m_prev) * p, len);
                    default: val = m_cur;
                endcase
                exp_v[cyc + 3 + p] = val;
            end
            reads++;
        end
    endtask

    task automatic run_reads(input logic [1:0] md, input int rl, input int n);
        int guard;
        guard = 0;
        while (reads < n && guard < 200) begin
            step(1'b1, md, rl);
            guard++;
        end
        chk("read_budget", reads, n);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, mode, int'(ratio_log2));
    endtask

    initial begin
        tbl[0] = '{md: 2'b00, r: 0, n: 3, din: '{5, -3, 9}, nout: 3,
                   dq: '{5, -3, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        tbl[1] = '{md: 2'b11, r: 2, n: 3, din: '{100, 200, -200}, nout: 12,
                   dq: '{100, 100, 100, 100, 100, 125, 150, 175, 200, 100, 0, -100}};
        tbl[2] = '{md: 2'b10, r: 2, n: 2, din: '{7, -8, 0}, nout: 8,
                   dq: '{7, 0, 0, 0, -8, 0, 0, 0, 0, 0, 0, 0}};
        tbl[3] = '{md: 2'b01, r: 2, n: 2, din: '{7, -8, 0}, nout: 8,
                   dq: '{7, 7, 7, 7, -8, -8, -8, -8, 0, 0, 0, 0}};

        reset_dut();
        #1;
        chk("reset_dout", int'(dout), 0);
        chk("reset_valid", int'(dout_valid), 0);

        // Table-driven directed sequences.
        for (int k = 0; k < 4; k++) begin
            reset_dut();
            for (int i = 0; i < tbl[k].n; i++) in_q.push_back(tbl[k].din[i]);
            run_reads(tbl[k].md, tbl[k].r, tbl[k].n);
            drain(30);
            chk($sformatf("tbl%0d_count", k), out_q.size(), tbl[k].nout);
            for (int i = 0; i < tbl[k].nout && i < out_q.size(); i++)
                chk($sformatf("tbl%0d_out%0d", k, i), out_q[i], tbl[k].dq[i]);
        end

        // Extremes: full-scale step at R=4.
        reset_dut();
        in_q.push_back(32767);
        in_q.push_back(-32768);
        run_reads(2'b11, 4, 2);
        drain(40);
        chk("ext_count", out_q.size(), 32);
        if (out_q.size() == 32) begin
            chk("ext_primed", out_q[15], 32767);
            chk("ext_ph0", out_q[16], 32767);
            chk("ext_ph15", out_q[31], -28673);
        end

        // Underflow: linear R=1, gap after the second read, then resume.
        reset_dut();
        in_q.push_back(10);
        in_q.push_back(20);
        in_q.push_back(40);
        run_reads(2'b11, 1, 2);
        for (int i = 0; i < 10; i++) step(1'b0, 2'b11, 1);
        run_reads(2'b11, 1, 3);
        drain(20);
        chk("uf_count", out_q.size(), 6);
        if (out_q.size() == 6) begin
            chk("uf_out3", out_q[3], 15);
            chk("uf_out4", out_q[4], 20);
            chk("uf_out5", out_q[5], 30);
        end

        // Reset mid-period, then re-prime.
        reset_dut();
        in_q.push_back(100);
        in_q.push_back(200);
        run_reads(2'b11, 2, 2);
        step(1'b0, 2'b11, 2);
        step(1'b0, 2'b11, 2);
        ena = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", int'(dout), 0);
        chk("mid_rst_valid", int'(dout_valid), 0);
        chk("mid_rst_rd_en", int'(rd_en), 1);
        reset_dut();
        in_q.push_back(50);
        in_q.push_back(60);
        run_reads(2'b11, 2, 2);
        drain(20);
        chk("rst_count", out_q.size(), 8);
        if (out_q.size() == 8) begin
            chk("rst_primed0", out_q[0], 50);
            chk("rst_primed3", out_q[3], 50);
            chk("rst_seg1", out_q[5], 52);
            chk("rst_seg3", out_q[7], 57);
        end

        // Randomized run against the model: random ena, mode and R every cycle.
        reset_dut();
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 3) != 0, 2'($urandom), int'($urandom_range(0, 7)));
        drain(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
